// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage and its neighbours.
//   - DW / RW     : operand and result widths of the 8-bit ALU
//   - OP_*        : ALU opcode encodings (OP_AND = 4'b0000 .. OP_REDOR = 4'b1111)
//   - state_e     : issue-stage FSM states (IDLE, ISSUE, RESP)
//   - cmd_t       : one buffered command (opcode + both operands)
//   - is_div_by_zero() : detects the one case the ALU does not guard
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DW = 8;
  localparam int RW = 16;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_NOT    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_MUL    = 4'b0110;
  localparam logic [3:0] OP_CMP    = 4'b0111;
  localparam logic [3:0] OP_DIV    = 4'b1000;
  localparam logic [3:0] OP_CAT    = 4'b1001;
  localparam logic [3:0] OP_MOD    = 4'b1010;
  localparam logic [3:0] OP_SHL    = 4'b1011;
  localparam logic [3:0] OP_SHR    = 4'b1100;
  localparam logic [3:0] OP_INC    = 4'b1101;
  localparam logic [3:0] OP_REDAND = 4'b1110;
  localparam logic [3:0] OP_REDOR  = 4'b1111;

  // Result substituted for a divide by zero; the ALU output is ignored then.
  localparam logic [RW-1:0] DIVZ_RESULT = {RW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  function automatic logic is_div_by_zero(input logic [3:0] sel, input logic [DW-1:0] b);
    return (sel == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
// Command and result handshake bundle of the ALU issue stage.
//   Command channel : cmd_valid, cmd_ready, cmd_a, cmd_b, cmd_sel
//   Result channel  : res_valid, res_ready, res_data, res_sel, res_err
// Modports:
//   slave  - the issue stage (consumes commands, produces results)
//   master - the upstream producer / downstream consumer side
// ---------------------------------------------------------------------------
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [3:0]    cmd_sel;

  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_data;
  logic [3:0]    res_sel;
  logic          res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    output cmd_ready, res_valid, res_data, res_sel, res_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, res_ready,
    input  cmd_ready, res_valid, res_data, res_sel, res_err
  );

endinterface

// File: rtl/alu_issue_fifo.sv
// ---------------------------------------------------------------------------
// alu_issue_fifo
// Small synchronous FIFO holding pending ALU commands.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write din when push && !full
//   pop, dout    : dout shows the head entry; pop advances when !empty
//   full, empty  : occupancy flags derived from the registered count
// A simultaneous push and pop leaves the count unchanged. Pointers wrap
// modulo DEPTH, which must be a power of two >= 2.
// ---------------------------------------------------------------------------
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an entry is only ever read after it was written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Sequencer in front of the combinational 8-bit ALU. Commands are buffered
// in a DEPTH-entry FIFO, issued one at a time on registered operand lines,
// and the ALU result is captured and returned over a valid/ready channel.
// A divide (OP_DIV) with b == 0 returns 16'hFFFF with res_err set.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command channel in, result channel out
//   alu_a/b/sel     : registered operands/opcode driven to the ALU
//   alu_out         : ALU combinational result, sampled in ISSUE
//   stat_issued     : commands issued (saturating)
//   stat_divz       : divide-by-zero results (saturating)
//
// Build option: define ALU_ISSUE_STATS_EN to enable the two statistics
// counters. Without it both stat ports are tied to zero.
//
// Timing: handshake in cycle T -> FIFO write T, pop T+1, ISSUE T+2,
// res_valid visible in T+3. At most one result every two cycles.
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_stage_if.slave     bus,
  output logic [DW-1:0]        alu_a,
  output logic [DW-1:0]        alu_b,
  output logic [3:0]           alu_sel,
  input  logic [RW-1:0]        alu_out,
  output logic [15:0]          stat_issued,
  output logic [15:0]          stat_divz
);

  cmd_t fifo_din;
  cmd_t fifo_dout;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;

  state_e        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic [3:0]    res_sel_q, res_sel_d;
  logic          res_err_q, res_err_d;
  logic          res_valid_q, res_valid_d;
  logic          divz;

  // No pass-through: a command written this cycle is first visible next cycle.
  assign bus.cmd_ready = !fifo_full;
  assign fifo_push     = bus.cmd_valid && !fifo_full;
  assign fifo_din      = '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign divz = is_div_by_zero(alu_sel_q, alu_b_q);

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Operands have been stable for this whole cycle; sample the ALU.
        res_data_d  = divz ? DIVZ_RESULT : alu_out;
        res_sel_d   = alu_sel_q;
        res_err_d   = divz;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Operand registers change only on a pop and hold otherwise.
    if (fifo_pop) begin
      alu_a_d   = fifo_dout.a;
      alu_b_d   = fifo_dout.b;
      alu_sel_d = fifo_dout.sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_sel       = alu_sel_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_sel   = res_sel_q;
  assign bus.res_err   = res_err_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_divz_q, stat_divz_d;

  // Every pop is an entry into ISSUE; every ISSUE cycle is a capture.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_divz_d   = stat_divz_q;
    if (fifo_pop && (stat_issued_q != 16'hFFFF)) begin
      stat_issued_d = stat_issued_q + 16'd1;
    end
    if ((state_q == ISSUE) && divz && (stat_divz_q != 16'hFFFF)) begin
      stat_divz_d = stat_divz_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_divz_q   <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_divz_q   <= stat_divz_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_divz   = stat_divz_q;
`else
  assign stat_issued = '0;
  assign stat_divz   = '0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed bench for alu_issue_stage with a behavioural model of the 8-bit
// ALU on the alu_* ports. Expected results are queued when a command is
// accepted and compared when the result handshake happens. Honours
// ALU_ISSUE_STATS_EN for the expected statistics values.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_sel;
  logic [RW-1:0] alu_out;
  logic [15:0]   stat_issued;
  logic [15:0]   stat_divz;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .stat_issued (stat_issued),
    .stat_divz   (stat_divz)
  );

  // Behavioural ALU. Divide/modulo by zero returns 16'hDEAD so the bench
  // can see that the stage substitutes its own value.
  logic [15:0] ua;
  logic [15:0] ub;
  always_comb begin
    ua = {8'h00, alu_a};
    ub = {8'h00, alu_b};
    alu_out = 16'h0000;
    case (alu_sel)
      OP_AND:    alu_out = ua & ub;
      OP_OR:     alu_out = ua | ub;
      OP_XOR:    alu_out = ua ^ ub;
      OP_NOT:    alu_out = {8'h00, ~alu_a};
      OP_ADD:    alu_out = ua + ub;
      OP_SUB:    alu_out = ua - ub;
      OP_MUL:    alu_out = ua * ub;
      OP_CMP:    alu_out = {15'h0000, (alu_a < alu_b)};
      OP_DIV:    alu_out = (alu_b == 8'h00) ? 16'hDEAD : ua / ub;
      OP_CAT:    alu_out = {alu_a, alu_b};
      OP_MOD:    alu_out = (alu_b == 8'h00) ? 16'hDEAD : ua % ub;
      OP_SHL:    alu_out = ua << 1;
      OP_SHR:    alu_out = ua >> 1;
      OP_INC:    alu_out = ua + 16'd1;
      OP_REDAND: alu_out = {15'h0000, &alu_a};
      OP_REDOR:  alu_out = {15'h0000, |alu_a};
      default:   alu_out = 16'h0000;
    endcase
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_assert    = 0;
  int n_fail      = 0;
  int n_results   = 0;
  int last_res_cyc = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: scoreboard compare, spacing and hold-stability checks.
  logic        hold_pending = 1'b0;
  logic [15:0] hold_data;
  logic [3:0]  hold_sel;
  logic        hold_err;

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
      last_res_cyc = -100;
    end else begin
      if (hold_pending) begin
        check("hold_res_valid", 32'(bus.res_valid), 32'd1);
        check("hold_res_data",  32'(bus.res_data),  32'(hold_data));
        check("hold_res_sel",   32'(bus.res_sel),   32'(hold_sel));
        check("hold_res_err",   32'(bus.res_err),   32'(hold_err));
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("res_data", 32'(bus.res_data), 32'(mon_e.data));
          check("res_sel",  32'(bus.res_sel),  32'(mon_e.sel));
          check("res_err",  32'(bus.res_err),  32'(mon_e.err));
          check("res_spacing_ge2", 32'((cyc - last_res_cyc) >= 2), 32'd1);
          last_res_cyc = cyc;
          n_results++;
        end
      end
      hold_pending = bus.res_valid && !bus.res_ready;
      hold_data    = bus.res_data;
      hold_sel     = bus.res_sel;
      hold_err     = bus.res_err;
    end
  end

  always @(posedge clk) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog cycles=%0d limit=5000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [15:0] ed, input logic ee, input int max_wait,
                      output bit accepted);
    exp_t e;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    accepted      = 1'b0;
    for (int i = 0; i < max_wait && !accepted; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        accepted = 1'b1;
        e.data = ed;
        e.sel  = sel;
        e.err  = ee;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_complete", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit          acc;
    int          n_acc;
    int          k;
    int          r0;
    logic [7:0]  ta;
    logic [7:0]  tb;

    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.res_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_res_valid",   32'(bus.res_valid), 32'd0);
    check("rst_cmd_ready",   32'(bus.cmd_ready), 32'd1);
    check("rst_alu_a",       32'(alu_a),         32'd0);
    check("rst_alu_b",       32'(alu_b),         32'd0);
    check("rst_alu_sel",     32'(alu_sel),       32'd0);
    check("rst_res_data",    32'(bus.res_data),  32'd0);
    check("rst_res_sel",     32'(bus.res_sel),   32'd0);
    check("rst_res_err",     32'(bus.res_err),   32'd0);
    check("rst_stat_issued", 32'(stat_issued),   32'd0);
    check("rst_stat_divz",   32'(stat_divz),     32'd0);
    @(posedge clk);
    #1;

    // Single command with latency measurement
    bus.res_ready = 1'b1;
    send(8'd42, 8'd240, OP_CAT, 16'h2AF0, 1'b0, 20, acc);
    check("single_accepted", 32'(acc), 32'd1);
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(negedge clk);
      if (bus.res_valid) k = i;
    end
    check("latency_cycles_after_T", 32'(k), 32'd3);
    @(posedge clk);
    #1;
    drain(20);

    // Back-to-back commands
    send(8'd42, 8'd240, OP_DIV, 16'd0,  1'b0, 20, acc);
    check("b2b_first_accepted", 32'(acc), 32'd1);
    send(8'd42, 8'd240, OP_SHR, 16'd21, 1'b0, 20, acc);
    check("b2b_second_accepted", 32'(acc), 32'd1);
    drain(30);

    // Divide by zero, then a normal op
    send(8'd42, 8'd0,   OP_DIV, 16'hFFFF, 1'b1, 20, acc);
    check("divz_accepted", 32'(acc), 32'd1);
    send(8'd42, 8'd240, OP_AND, 16'd32,   1'b0, 20, acc);
    check("and_accepted", 32'(acc), 32'd1);
    drain(30);

    // Backpressure: 6 offers back-to-back, 5 fit (4 buffered + 1 in flight)
    bus.res_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ta = 8'(60 + i * 37);
      tb = 8'(250 - i * 11);
      send(ta, tb, OP_ADD, {8'h00, ta} + {8'h00, tb}, 1'b0, 1, acc);
      if (acc) n_acc++;
    end
    check("bp_accepted_count", 32'(n_acc), 32'd5);
    @(negedge clk);
    check("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("bp_res_valid_high", 32'(bus.res_valid), 32'd1);
    repeat (4) @(negedge clk);
    check("bp_res_data_head", 32'(bus.res_data), 32'(sb[0].data));
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    r0 = n_results;
    drain(60);
    check("bp_drained_results", 32'(n_results - r0), 32'd5);

    // Reset during ISSUE with 3 commands queued
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ta = 8'(17 + i * 9);
      tb = 8'(5 + i);
      send(ta, tb, OP_ADD, {8'h00, ta} + {8'h00, tb}, 1'b0, 1, acc);
      check("rstmid_accepted", 32'(acc), 32'd1);
    end
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(negedge clk);
      if (bus.res_valid) k = i;
    end
    check("rstmid_first_result_seen", 32'(k != 0), 32'd1);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;          // RESP handshake at the end of this cycle
    @(posedge clk);
    #1;                            // now in ISSUE for the second command
    rst = 1'b1;
    sb.delete();                   // queued and in-flight commands are discarded
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_res_valid", 32'(bus.res_valid), 32'd0);
    check("rstmid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rstmid_alu_a",     32'(alu_a),         32'd0);
    check("rstmid_alu_b",     32'(alu_b),         32'd0);
    check("rstmid_alu_sel",   32'(alu_sel),       32'd0);
    r0 = n_results;
    repeat (12) @(posedge clk);
    #1;
    check("rstmid_no_stale_result", 32'(n_results - r0), 32'd0);
    check("rstmid_res_valid_idle", 32'(bus.res_valid), 32'd0);

    // Statistics: 3 issues, 1 divide by zero since the last reset
    send(8'd42, 8'd0,   OP_DIV, 16'hFFFF, 1'b1, 20, acc);
    check("stats_cmd0_accepted", 32'(acc), 32'd1);
    send(8'd42, 8'd240, OP_CAT, 16'h2AF0, 1'b0, 20, acc);
    check("stats_cmd1_accepted", 32'(acc), 32'd1);
    send(8'd7,  8'd3,   OP_ADD, 16'd10,   1'b0, 20, acc);
    check("stats_cmd2_accepted", 32'(acc), 32'd1);
    drain(40);
    repeat (2) @(negedge clk);
`ifdef ALU_ISSUE_STATS_EN
    check("stat_issued", 32'(stat_issued), 32'd3);
    check("stat_divz",   32'(stat_divz),   32'd1);
`else
    check("stat_issued", 32'(stat_issued), 32'd0);
    check("stat_divz",   32'(stat_divz),   32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequencer directly upstream of the team's combinational 8-bit ALU (inputs a[7:0], b[7:0], sel[3:0]; output out[15:0]).
- Accepts ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered, stable operands to the ALU, samples its result and returns it over a valid/ready result interface.
- Flags divide-by-zero, which the ALU does not guard.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- DW, 8, operand width; fixed at 8 to match the ALU.
- RW, 16, result width; fixed at 16 to match the ALU.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_a  in  DW  operand a.
- cmd_b  in  DW  operand b.
- cmd_sel  in  4  ALU opcode.
- alu_a  out  DW  registered operand a to ALU.
- alu_b  out  DW  registered operand b to ALU.
- alu_sel  out  4  registered opcode to ALU.
- alu_out  in  RW  ALU combinational result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  RW  captured result.
- res_sel  out  4  opcode that produced res_data.
- res_err  out  1  divide-by-zero flag.
- stat_issued  out  16  issued-command count (optional feature).
- stat_divz  out  16  divide-by-zero count (optional feature).

Behaviour:
- Reset (sync, active-high): FIFO emptied; FSM to IDLE. alu_a, alu_b, alu_sel, res_data, res_sel, res_err, res_valid and both stat counters all 0. cmd_ready is 1 in the first cycle after reset. Reset mid-operation discards any buffered or in-flight command; no result is emitted for it.
- Command accept: a handshake occurs when cmd_valid && cmd_ready; the command is written to the FIFO.
  - cmd_ready = !fifo_full, with no same-cycle push/pop pass-through.
  - Push to a full FIFO is impossible by construction.
- FSM:
  - IDLE: if FIFO non-empty, pop into alu_a/alu_b/alu_sel and go to ISSUE.
  - ISSUE: operands are stable at the ALU for the full cycle. At the clock edge, capture alu_out into res_data and alu_sel into res_sel, compute res_err, set res_valid=1 and go to RESP.
  - RESP: hold res_* stable while res_valid && !res_ready. On handshake:
    - FIFO non-empty: pop into the operand registers and go to ISSUE (res_valid=0 in ISSUE).
    - Otherwise: clear res_valid and go to IDLE.
- Operand registers change only on a pop; they hold their value through RESP and IDLE.
- Latency: command handshake in cycle T gives res_valid in cycle T+3 (FIFO write T, pop T+1, ISSUE T+2).
- Throughput: at most one result per 2 cycles.
- Capacity: DEPTH commands buffered plus 1 in flight.
- Divide-by-zero: when alu_sel==OP_DIV (4'b1000) and alu_b==0, res_err=1 and res_data=16'hFFFF (ALU value ignored). Otherwise res_err=0.
- Simultaneous push and pop in one cycle: both take effect and the count is unchanged. The FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - stat_issued increments on every entry to ISSUE.
  - stat_divz increments on every capture with res_err=1.
  - Both are 16-bit saturating at 16'hFFFF and cleared by rst.
- Undefined: both ports are tied to 0 and no counter logic is present. The port list is identical in both builds.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_AND..OP_REDOR (4'b0000..4'b1111), including OP_DIV=4'b1000;
  - DW/RW constants;
  - FSM state encoding: IDLE, ISSUE, RESP.
- Sub-module alu_issue_fifo: synchronous FIFO parameterised by DEPTH and width 2*DW+4. Ports: push, pop, full, empty, din, dout.
- The bench instantiates the ALU on the alu_* ports.

Test Plan:
- Single command a=42, b=240, sel=4'b1001, res_ready=1 -> res_valid at T+3, res_data=10992 (16'h2AF0), res_sel=9, res_err=0.
- Back-to-back commands (42,240) with sel=8 then sel=12 -> res_data=0 then 21, in order, at least 2 cycles apart.
- Divide-by-zero: a=42, b=0, sel=8 -> res_data=16'hFFFF, res_err=1. Then a=42, b=240, sel=0 -> res_data=32, res_err=0.
- Backpressure: res_ready=0, push 6 commands back-to-back -> exactly 5 accepted, then cmd_ready=0. res_data stays stable; releasing res_ready drains 5 results in order.
- Reset mid-operation: rst in the ISSUE cycle with 3 commands queued -> the next cycle has res_valid=0, cmd_ready=1 and alu_* = 0, and no stale result ever appears.
- With ALU_ISSUE_STATS_EN: 3 commands including 1 divide-by-zero -> stat_issued=3, stat_divz=1. Without the macro -> both remain 0.
